// File: rtl/alu_pkg.sv
// Shared encodings for the serial add/subtract unit: operation codes,
// controller states and the operand-conditioning helpers.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_ADC = 2'b10,
      OP_SBB = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Subtracting forms feed ~b into the adder.
   function automatic logic op_inverts_b(input op_e op);
      return (op == OP_SUB) || (op == OP_SBB);
   endfunction

   // Initial carry: fixed for ADD/SUB, taken from cin for ADC/SBB
   // (for SBB, cin=1 means no borrow).
   function automatic logic op_carry_in(input op_e op, input logic cin);
      logic c;
      case (op)
         OP_ADD:  c = 1'b0;
         OP_SUB:  c = 1'b1;
         default: c = cin;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// CHUNK-bit combinational ripple adder built from 1-bit full adders.
module adder_slice #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic [CHUNK:0] c;

   assign c[0] = cin;

   // Ripple chain: each stage is a plain full adder.
   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
   end

   assign cout = c[CHUNK];

endmodule

// File: rtl/serial_addsub.sv
// Serial add/subtract unit: one CHUNK-bit slice per cycle, LSB slice first.
// Optional build macro ADDSUB_FLAGS_EN enables the zero and ovf flags;
// without it both flags read 0. WIDTH must be a multiple of CHUNK.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for an operation, in_ready=1
// ST_BUSY | adding one slice per cycle, counter selects the slice
// ST_DONE | result held with out_valid=1 until out_ready
module serial_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [1:0]       s_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             zero,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   state_e state_q, state_d;

   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q, s_q;
   logic             carry_q, cout_q, zero_q, ovf_q;

   logic [CHUNK-1:0] slice_s;
   logic             slice_cout;
   logic [WIDTH-1:0] s_next;
   logic             zero_nxt, ovf_nxt;
   logic             accept, busy, last_slice;
   op_e              op_in;

   assign op_in      = op_e'(s_op);
   assign in_ready   = (state_q == ST_IDLE);
   assign out_valid  = (state_q == ST_DONE);
   assign accept     = in_valid & in_ready;
   assign busy       = (state_q == ST_BUSY);
   assign last_slice = busy && (cnt_q == LAST);

   adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (a_q[CHUNK-1:0]),
      .b    (b_q[CHUNK-1:0]),
      .cin  (carry_q),
      .s    (slice_s),
      .cout (slice_cout)
   );

   // The result register fills from the top so the LSB slice ends up at bit 0.
   if (CHUNK == WIDTH) begin : g_one
      assign s_next = slice_s;
   end else begin : g_multi
      assign s_next = {slice_s, s_q[WIDTH-1:CHUNK]};
   end

`ifdef ADDSUB_FLAGS_EN
   // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
   logic c_msb;
   assign c_msb    = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice_s[CHUNK-1];
   assign zero_nxt = (s_next == '0);
   assign ovf_nxt  = c_msb ^ slice_cout;
`else
   assign zero_nxt = 1'b0;
   assign ovf_nxt  = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)            state_d = ST_BUSY;
         ST_BUSY: if (cnt_q == LAST)       state_d = ST_DONE;
         ST_DONE: if (out_ready)           state_d = ST_IDLE;
         default:                          state_d = ST_IDLE;
      endcase
   end

   // Operand capture, per-slice shift/add and result/flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         cnt_q   <= '0;
         a_q     <= a;
         b_q     <= op_inverts_b(op_in) ? ~b : b;
         carry_q <= op_carry_in(op_in, cin);
      end else if (busy) begin
         cnt_q   <= cnt_q + CW'(1);
         a_q     <= a_q >> CHUNK;
         b_q     <= b_q >> CHUNK;
         s_q     <= s_next;
         carry_q <= slice_cout;
         if (last_slice) begin
            cout_q <= slice_cout;
            zero_q <= zero_nxt;
            ovf_q  <= ovf_nxt;
         end
      end
   end

   assign s    = s_q;
   assign cout = cout_q;
   assign zero = zero_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
   import alu_pkg::*;

`ifdef ADDSUB_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic        cin;
   logic [1:0]  s_op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] s;
   logic        cout, zero, ovf;

   int n_chk  = 0;
   int n_fail = 0;

   serial_addsub #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .s_op(s_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .cout(cout), .zero(zero), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one operation and check latency, result, hold behaviour and release.
   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input op_e op, input logic [15:0] es,
                         input logic ec, input logic ez, input logic eo, input int hold);
      int cyc;
      a = av; b = bv; cin = ci; s_op = op; in_valid = 1'b1;
      check({tag, " in_ready before accept"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = ~av; b = ~bv; cin = ~ci;
      check({tag, " in_ready busy"}, in_ready, 0);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, " latency"}, cyc, 4);
      check({tag, " s"}, s, es);
      check({tag, " cout"}, cout, ec);
      check({tag, " zero"}, zero, FLAGS ? ez : 1'b0);
      check({tag, " ovf"}, ovf, FLAGS ? eo : 1'b0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a = 16'h0F0F ^ 16'(i); b = 16'h1234;
         @(posedge clk); #1;
         check({tag, " hold out_valid"}, out_valid, 1);
         check({tag, " hold in_ready"}, in_ready, 0);
         check({tag, " hold s"}, s, es);
         check({tag, " hold cout"}, cout, ec);
         check({tag, " hold ovf"}, ovf, FLAGS ? eo : 1'b0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " release out_valid"}, out_valid, 0);
      check({tag, " release in_ready"}, in_ready, 1);
   endtask

   // Directed sequence.
   initial begin
      int cyc;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; s_op = OP_ADD;
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset s", s, 0);
      check("reset cout", cout, 0);
      check("reset zero", zero, 0);
      check("reset ovf", ovf, 0);
      rst = 1'b0;

      run_op("add_1234", 16'h1234, 16'h1111, 1'b0, OP_ADD, 16'h2345, 1'b0, 1'b0, 1'b0, 0);
      run_op("sub_0m1",  16'h0000, 16'h0001, 1'b0, OP_SUB, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
      run_op("sub_8000", 16'h8000, 16'h0001, 1'b0, OP_SUB, 16'h7FFF, 1'b1, 1'b0, 1'b1, 0);
      run_op("adc_ffff", 16'hFFFF, 16'h0000, 1'b1, OP_ADC, 16'h0000, 1'b1, 1'b1, 1'b0, 0);
      run_op("sbb_5m3",  16'h0005, 16'h0003, 1'b0, OP_SBB, 16'h0001, 1'b1, 1'b0, 1'b0, 0);
      run_op("add_7fff_hold", 16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b0, 1'b1, 5);

      // Abort during the second BUSY cycle, with in_valid also high.
      a = 16'h00FF; b = 16'h0001; cin = 1'b0; s_op = OP_ADD; in_valid = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      check("abort out_valid", out_valid, 0);
      check("abort in_ready", in_ready, 1);
      check("abort s", s, 0);
      cyc = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid) cyc++;
      end
      check("abort no result", cyc, 0);
      run_op("add_after_abort", 16'h0001, 16'h0001, 1'b0, OP_ADD, 16'h0002, 1'b0, 1'b0, 1'b0, 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
